hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - register scoreboard with RAW/overflow stall, redirect flush and stall statistics
// Tracks up to three in-flight writes per architectural register and holds decode on hazards.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_issue_valid,
  input  logic [4:0]       i_issue_rd,
  input  logic             i_issue_wr,
  input  logic [4:0]       i_rs1_addr,
  input  logic [4:0]       i_rs2_addr,
  input  logic             i_rs1_used,
  input  logic             i_rs2_used,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_redirect,
  output logic             o_stall,
  output logic             o_flush,
  output logic [31:0]      o_busy,
  output logic [CNT_W-1:0] o_stall_count
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_flush_cnt;
  logic [3:0]       w_flush_cnt_nxt;
  logic [1:0]       r_cnt [32];
  logic [31:0]      w_busy;
  logic [31:0]      w_inc;
  logic [31:0]      w_dec;
  logic [CNT_W-1:0] r_stall_count;
  logic             w_flush;
  logic             w_raw1;
  logic             w_raw2;
  logic             w_ovf;
  logic             w_stall;
  logic             w_fire;

  always_comb begin
    w_busy = '0;
    for (int n = 1; n < 32; n++) begin
      w_busy[n] = (r_cnt[n] != 2'd0);
    end
  end

  assign w_flush = (r_state == ST_FLUSH);

  // A source with exactly one pending write that retires this cycle is forwarded from writeback.
  assign w_raw1 = i_rs1_used && (i_rs1_addr != 5'd0) && w_busy[i_rs1_addr] &&
                  !(i_wb_valid && (i_wb_rd == i_rs1_addr) && (r_cnt[i_rs1_addr] == 2'd1));
  assign w_raw2 = i_rs2_used && (i_rs2_addr != 5'd0) && w_busy[i_rs2_addr] &&
                  !(i_wb_valid && (i_wb_rd == i_rs2_addr) && (r_cnt[i_rs2_addr] == 2'd1));
  assign w_ovf  = i_issue_wr && (i_issue_rd != 5'd0) && (r_cnt[i_issue_rd] == 2'd3);

  assign w_stall = i_issue_valid && !w_flush && (w_raw1 || w_raw2 || w_ovf);
  assign w_fire  = i_issue_valid && !w_stall && !w_flush;

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    if (w_fire && i_issue_wr && (i_issue_rd != 5'd0)) begin
      w_inc[i_issue_rd] = 1'b1;
    end
    if (i_wb_valid && (i_wb_rd != 5'd0) && (r_cnt[i_wb_rd] != 2'd0)) begin
      w_dec[i_wb_rd] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    r_cnt[0] <= 2'd0;
    for (int n = 1; n < 32; n++) begin
      if (i_reset) begin
        r_cnt[n] <= 2'd0;
      end else if (w_inc[n] && !w_dec[n]) begin
        r_cnt[n] <= r_cnt[n] + 2'd1;
      end else if (w_dec[n] && !w_inc[n]) begin
        r_cnt[n] <= r_cnt[n] - 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // A redirect inside the flush window restarts the full window.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      ST_RUN: begin
        if (i_redirect) begin
          w_state_nxt     = ST_FLUSH;
          w_flush_cnt_nxt = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (i_redirect) begin
          w_flush_cnt_nxt = FLUSH_LOAD;
        end else if (r_flush_cnt == 4'd1) begin
          w_state_nxt     = ST_RUN;
          w_flush_cnt_nxt = 4'd0;
        end else begin
          w_flush_cnt_nxt = r_flush_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt     = ST_RUN;
        w_flush_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + 1'b1;
    end
  end

  assign o_stall       = w_stall;
  assign o_flush       = w_flush;
  assign o_busy        = w_busy;
  assign o_stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a per-register pending-write model
module tb_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 16;
  localparam int SAT          = 65535;

  logic             clk = 1'b0;
  logic             reset;
  logic             iv;
  logic [4:0]       ird;
  logic             iwr;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             u1;
  logic             u2;
  logic             wbv;
  logic [4:0]       wbrd;
  logic             redir;
  logic             stall;
  logic             flush;
  logic [31:0]      busy;
  logic [CNT_W-1:0] scnt;

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt [32];
  int m_flush_left;
  int m_scnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_issue_valid (iv),
    .i_issue_rd    (ird),
    .i_issue_wr    (iwr),
    .i_rs1_addr    (rs1),
    .i_rs2_addr    (rs2),
    .i_rs1_used    (u1),
    .i_rs2_used    (u2),
    .i_wb_valid    (wbv),
    .i_wb_rd       (wbrd),
    .i_redirect    (redir),
    .o_stall       (stall),
    .o_flush       (flush),
    .o_busy        (busy),
    .o_stall_count (scnt)
  );

  function automatic logic [31:0] exp_busy();
    logic [31:0] b;
    b = '0;
    for (int n = 1; n < 32; n++) b[n] = (m_cnt[n] > 0);
    return b;
  endfunction

  function automatic bit src_hazard(input logic used, input logic [4:0] a);
    if (!used || a == 5'd0 || m_cnt[a] == 0) return 1'b0;
    if (m_cnt[a] == 1 && wbv && wbrd == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_stall();
    if (m_flush_left > 0 || !iv) return 1'b0;
    if (iwr && ird != 5'd0 && m_cnt[ird] == 3) return 1'b1;
    return src_hazard(u1, rs1) || src_hazard(u2, rs2);
  endfunction

  function automatic void model_update();
    bit st;
    bit fire;
    if (reset) begin
      for (int n = 0; n < 32; n++) m_cnt[n] = 0;
      m_flush_left = 0;
      m_scnt = 0;
      return;
    end
    st   = exp_stall();
    fire = iv && !st && (m_flush_left == 0);
    if (wbv && wbrd != 5'd0 && m_cnt[wbrd] > 0) m_cnt[wbrd] = m_cnt[wbrd] - 1;
    if (fire && iwr && ird != 5'd0) m_cnt[ird] = m_cnt[ird] + 1;
    if (st && m_scnt < SAT) m_scnt = m_scnt + 1;
    if (redir) m_flush_left = FLUSH_CYCLES;
    else if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    iv = 0; ird = 0; iwr = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0;
    wbv = 0; wbrd = 0; redir = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle();
    iv = 1; iwr = 1; ird = 5'd3; redir = 1; wbv = 1; wbrd = 5'd3;
    tick(); tick();
    @(negedge clk);
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush_prio: got %0b expected 0", flush); end
    n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy_prio: got %h expected 0", busy); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", stall); end
    n_checks++; if (scnt !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", scnt); end
    tick();
    reset = 0; idle();
    tick();
  endtask

  task automatic test_raw();
    idle(); iv = 1; iwr = 1; ird = 5'd5;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_first_issue: got %0b expected 0", stall); end
    tick();
    idle(); iv = 1; rs1 = 5'd5; u1 = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (stall !== 1'b1 || stall !== exp_stall()) begin n_fail++; $display("FAIL raw_hold: got %0b expected 1", stall); end
      tick();
    end
    wbv = 1; wbrd = 5'd5;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL raw_wb_forward: got %0b expected 0", stall); end
    tick();
    idle();
    @(negedge clk);
    n_checks++; if (busy[5] !== 1'b0 || busy !== exp_busy()) begin n_fail++; $display("FAIL raw_busy_clear: got %h expected %h", busy, exp_busy()); end
    tick();
  endtask

  task automatic test_overflow();
    idle(); iv = 1; iwr = 1; ird = 5'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ovf_fill%0d: got %0b expected 0", i, stall); end
      tick();
    end
    @(negedge clk);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ovf_stall: got %0b expected 1", stall); end
    tick();
    wbv = 1; wbrd = 5'd7;
    @(negedge clk);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ovf_wb_cycle: got %0b expected 1", stall); end
    tick();
    wbv = 0;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ovf_fourth_fires: got %0b expected 0", stall); end
    tick();
    @(negedge clk);
    n_checks++; if (stall !== 1'b1 || m_cnt[7] != 3) begin n_fail++; $display("FAIL ovf_back_to_3: got %0b expected 1", stall); end
    idle(); wbv = 1; wbrd = 5'd7;
    tick(); tick(); tick();
    idle();
    @(negedge clk);
    n_checks++; if (busy[7] !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: got %0b expected 0", busy[7]); end
    tick();
  endtask

  task automatic test_same_cycle();
    idle(); iv = 1; iwr = 1; ird = 5'd9;
    tick();
    wbv = 1; wbrd = 5'd9;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL same_issue_stall: got %0b expected 0", stall); end
    tick();
    idle();
    @(negedge clk);
    n_checks++; if (busy[9] !== 1'b1 || m_cnt[9] != 1) begin n_fail++; $display("FAIL same_cycle_busy: got %0b expected 1", busy[9]); end
    wbv = 1; wbrd = 5'd9;
    tick(); tick();
    idle();
    @(negedge clk);
    n_checks++; if (busy !== exp_busy() || busy[9] !== 1'b0) begin n_fail++; $display("FAIL wb_idle_ignored: got %h expected %h", busy, exp_busy()); end
    tick();
  endtask

  task automatic test_x0();
    idle(); iv = 1; iwr = 1; ird = 5'd0; rs1 = 5'd0; rs2 = 5'd0; u1 = 1; u2 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (stall !== 1'b0 || busy[0] !== 1'b0) begin n_fail++; $display("FAIL x0_%0d: got stall %0b busy0 %0b expected 0 0", i, stall, busy[0]); end
      tick();
    end
    idle(); wbv = 1; wbrd = 5'd15;
    tick();
    idle();
    @(negedge clk);
    n_checks++; if (busy !== 32'h0) begin n_fail++; $display("FAIL x0_idle_busy: got %h expected 0", busy); end
    tick();
  endtask

  task automatic test_flush();
    idle(); iv = 1; iwr = 1; ird = 5'd13;
    tick();
    idle(); redir = 1;
    @(negedge clk);
    n_checks++; if (flush !== 1'b0 || busy[13] !== 1'b1) begin n_fail++; $display("FAIL flush_pre: got flush %0b busy13 %0b expected 0 1", flush, busy[13]); end
    tick();
    redir = 0; iv = 1; iwr = 1; ird = 5'd12; wbv = 1; wbrd = 5'd13;
    @(negedge clk);
    n_checks++; if (flush !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL flush_t1: got flush %0b stall %0b expected 1 0", flush, stall); end
    tick();
    redir = 1; wbv = 0;
    @(negedge clk);
    n_checks++; if (flush !== 1'b1 || busy[13] !== 1'b0) begin n_fail++; $display("FAIL flush_t2: got flush %0b busy13 %0b expected 1 0", flush, busy[13]); end
    tick();
    redir = 0;
    for (int i = 3; i <= 4; i++) begin
      @(negedge clk);
      n_checks++; if (flush !== 1'b1 || flush !== (m_flush_left > 0)) begin n_fail++; $display("FAIL flush_t%0d: got %0b expected 1", i, flush); end
      tick();
    end
    iv = 0;
    @(negedge clk);
    n_checks++; if (flush !== 1'b0 || busy[12] !== 1'b0) begin n_fail++; $display("FAIL flush_end: got flush %0b busy12 %0b expected 0 0", flush, busy[12]); end
    tick();
    redir = 1;
    tick();
    redir = 0;
    @(negedge clk);
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL flush_before_reset: got %0b expected 1", flush); end
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL flush_reset_mid: got %0b expected 0", flush); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      iv    = ($urandom_range(0, 3) != 0);
      iwr   = ($urandom_range(0, 2) != 0);
      ird   = 5'($urandom_range(0, 7));
      rs1   = 5'($urandom_range(0, 7));
      rs2   = 5'($urandom_range(0, 7));
      u1    = $urandom_range(0, 1);
      u2    = $urandom_range(0, 1);
      wbv   = ($urandom_range(0, 2) != 0);
      wbrd  = 5'($urandom_range(0, 7));
      redir = ($urandom_range(0, 31) == 0);
      @(negedge clk);
      n_checks++; if (stall !== exp_stall()) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0b expected %0b", c, stall, exp_stall()); end
      n_checks++; if (flush !== (m_flush_left > 0)) begin n_fail++; $display("FAIL rnd_flush c%0d: got %0b expected %0b", c, flush, m_flush_left > 0); end
      n_checks++; if (busy !== exp_busy()) begin n_fail++; $display("FAIL rnd_busy c%0d: got %h expected %h", c, busy, exp_busy()); end
      n_checks++; if (scnt !== CNT_W'(m_scnt)) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d expected %0d", c, scnt, m_scnt); end
      tick();
    end
    idle();
  endtask

  task automatic test_saturate();
    idle(); iv = 1; iwr = 1; ird = 5'd20;
    tick();
    idle(); iv = 1; rs1 = 5'd20; u1 = 1;
    for (int c = 0; c < 70000; c++) tick();
    @(negedge clk);
    n_checks++; if (scnt !== 16'hFFFF || scnt !== CNT_W'(m_scnt)) begin n_fail++; $display("FAIL count_saturate: got %h expected ffff", scnt); end
    reset = 1;
    tick();
    reset = 0; idle();
    @(negedge clk);
    n_checks++; if (scnt !== '0) begin n_fail++; $display("FAIL count_after_reset: got %0d expected 0", scnt); end
    tick();
  endtask

  initial begin
    for (int n = 0; n < 32; n++) m_cnt[n] = 0;
    m_flush_left = 0;
    m_scnt = 0;
    test_reset();
    test_raw();
    test_overflow();
    test_same_cycle();
    test_x0();
    test_flush();
    test_random();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
